dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port data memory (negedge-sampled write/read, 32-bit daddress/din, registered dout).
- Port 0 is the CPU load/store stage; port 1 is the loader/debug port.
- Grants one access per two clocks using round-robin, with an optional lock for read-modify-write.
- Drives the memory command lines and returns captured read data to the winning port.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_rr_pick2.sv | 31 +++
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// +--------------------------------------------------------------------+
// | dmem_pkg : shared constants for the data-memory arbiter            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_DEPTH  = 1024;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_rr_pick2.sv
// +--------------------------------------------------------------------+
// | dmem_rr_pick2 : two-way round-robin pick with lock-owner masking   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       owner_valid,
  input  logic       owner,
  output logic       winner,
  output logic       any_eligible
);

  logic [1:0] w_elig;

  // A valid owner makes the other port invisible to arbitration.
  always_comb begin
    w_elig[P0] = req[P0] & ~(owner_valid & (owner == P1));
    w_elig[P1] = req[P1] & ~(owner_valid & (owner == P0));
  end

  assign any_eligible = |w_elig;
  assign winner       = (&w_elig) ? ~last : w_elig[P1];

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +--------------------------------------------------------------------+
// | dmem_arbiter : two-port round-robin sequencer for the data memory  |
// | Option macro: DMEM_ARB_RANGE_CHK_EN (address range check, pN_err)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_daddress,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef DMEM_ARB_RANGE_CHK_EN
  ,
  output logic              p0_err,
  output logic              p1_err
`endif
);

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit c_range_chk = 1'b1;
`else
  localparam bit c_range_chk = 1'b0;
`endif

  logic [0:0]        r_state;
  logic              r_last;
  logic              r_owner_valid;
  logic              r_owner;
  logic              r_win;
  logic              r_is_read;
  logic              r_oor;

  logic              w_lock_held;
  logic              w_winner;
  logic              w_any;
  logic              w_we;
  logic              w_lock;
  logic              w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Ownership survives an IDLE edge only while the owner keeps its lock up.
  assign w_lock_held = r_owner_valid & ((r_owner == P1) ? p1_lock : p0_lock);

  dmem_rr_pick2 u_pick (
    .req          ({p1_req, p0_req}),
    .last         (r_last),
    .owner_valid  (w_lock_held),
    .owner        (r_owner),
    .winner       (w_winner),
    .any_eligible (w_any)
  );

  assign w_addr  = (w_winner == P1) ? p1_addr  : p0_addr;
  assign w_wdata = (w_winner == P1) ? p1_wdata : p0_wdata;
  assign w_we    = (w_winner == P1) ? p1_we    : p0_we;
  assign w_lock  = (w_winner == P1) ? p1_lock  : p0_lock;
  assign w_oor   = c_range_chk & (w_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_last        <= P1;
      r_owner_valid <= 1'b0;
      r_owner       <= P0;
      r_win         <= P0;
      r_is_read     <= 1'b0;
      r_oor         <= 1'b0;
      p0_gnt        <= 1'b0;
      p1_gnt        <= 1'b0;
      p0_rvalid     <= 1'b0;
      p1_rvalid     <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
      mem_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_daddress  <= '0;
      mem_din       <= '0;
`ifdef DMEM_ARB_RANGE_CHK_EN
      p0_err        <= 1'b0;
      p1_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          p0_rvalid <= 1'b0;
          p1_rvalid <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHK_EN
          p0_err    <= 1'b0;
          p1_err    <= 1'b0;
`endif
          p0_gnt    <= w_any & (w_winner == P0);
          p1_gnt    <= w_any & (w_winner == P1);
          if (w_any) begin
            mem_daddress  <= w_addr;
            mem_din       <= w_wdata;
            mem_write     <= w_we & ~w_oor;
            mem_read      <= ~w_we & ~w_oor;
            r_win         <= w_winner;
            r_is_read     <= ~w_we;
            r_oor         <= w_oor;
            r_last        <= w_winner;
            r_owner_valid <= w_lock_held | w_lock;
            r_owner       <= w_lock ? w_winner : r_owner;
            r_state       <= ST_ACCESS;
          end else begin
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            r_owner_valid <= w_lock_held;
          end
        end
        default: begin
          // Memory answered on the negedge inside this cycle; mem_dout is settled.
          p0_gnt    <= 1'b0;
          p1_gnt    <= 1'b0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          if (r_is_read) begin
            if (r_win == P0) begin
              p0_rvalid <= 1'b1;
              p0_rdata  <= r_oor ? '0 : mem_dout;
            end else begin
              p1_rvalid <= 1'b1;
              p1_rdata  <= r_oor ? '0 : mem_dout;
            end
          end
`ifdef DMEM_ARB_RANGE_CHK_EN
          p0_err <= r_oor & (r_win == P0);
          p1_err <= r_oor & (r_win == P1);
`endif
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_dmem_arbiter : directed + random bench with transaction model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_arbiter;

  localparam int c_depth = 1024;
`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit c_range = 1'b1;
`else
  localparam bit c_range = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req, we, lock;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  wire  [1:0]  gnt, rvalid;
  wire  [31:0] rdata [2];
  wire         mem_write, mem_read;
  wire  [31:0] mem_daddress, mem_din;
  logic [31:0] mem_dout;
`ifdef DMEM_ARB_RANGE_CHK_EN
  wire  [1:0]  err;
`endif

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(c_depth)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lock[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_gnt(gnt[0]), .p0_rvalid(rvalid[0]), .p0_rdata(rdata[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lock[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_gnt(gnt[1]), .p1_rvalid(rvalid[1]), .p1_rdata(rdata[1]),
    .mem_write(mem_write), .mem_read(mem_read), .mem_daddress(mem_daddress),
    .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef DMEM_ARB_RANGE_CHK_EN
    , .p0_err(err[0]), .p1_err(err[1])
`endif
  );

  // Single-port memory: negedge-sampled strobes, registered read data.
  logic [31:0] phys_mem [c_depth];
  always @(negedge clock) begin
    if (mem_write) phys_mem[mem_daddress[9:0]] <= mem_din;
    if (mem_read)  mem_dout <= phys_mem[mem_daddress[9:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Transaction model: golden memory plus arbitration rules.
  logic [31:0] ref_mem [c_depth];
  bit          m_busy, m_own_v, m_pend_rd, m_pend_oor;
  int          m_last, m_own, m_pw;
  logic [31:0] m_pdata;
  logic [1:0]  e_gnt, e_rvalid, e_err;
  logic        e_wr, e_rd;
  logic [31:0] e_addr, e_din;
  logic [31:0] e_rdata [2];

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_own_v = 0; m_own = 0; m_pend_rd = 0; m_pend_oor = 0;
    m_pw = 0; m_pdata = '0;
    e_gnt = '0; e_rvalid = '0; e_err = '0; e_wr = 0; e_rd = 0;
    e_addr = '0; e_din = '0; e_rdata[0] = '0; e_rdata[1] = '0;
  endtask

  task automatic model_edge();
    bit el0, el1, oor;
    int w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    e_gnt = '0; e_rvalid = '0; e_err = '0;
    e_wr = 0; e_rd = 0;
    if (!m_busy) begin
      if (m_own_v && !lock[m_own]) m_own_v = 0;
      el0 = req[0] && !(m_own_v && m_own == 1);
      el1 = req[1] && !(m_own_v && m_own == 0);
      if (el0 || el1) begin
        w   = (el0 && el1) ? 1 - m_last : (el1 ? 1 : 0);
        oor = c_range && (addr[w] >= c_depth);
        e_gnt[w] = 1'b1;
        e_addr = addr[w];
        e_din  = wdata[w];
        e_wr   = we[w] && !oor;
        e_rd   = !we[w] && !oor;
        if (we[w]) begin
          if (!oor) ref_mem[addr[w][9:0]] = wdata[w];
          m_pend_rd = 0;
        end else begin
          m_pend_rd = 1;
          m_pdata   = oor ? 32'd0 : ref_mem[addr[w][9:0]];
        end
        m_pend_oor = oor;
        m_pw   = w;
        m_last = w;
        if (lock[w]) begin
          m_own   = w;
          m_own_v = 1;
        end
        m_busy = 1;
      end
    end else begin
      if (m_pend_rd) begin
        e_rvalid[m_pw] = 1'b1;
        e_rdata[m_pw]  = m_pdata;
      end
      if (m_pend_oor) e_err[m_pw] = 1'b1;
      m_busy = 0;
    end
  endtask

  task automatic compare();
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("rvalid", 32'(rvalid), 32'(e_rvalid));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("mem_read", 32'(mem_read), 32'(e_rd));
    chk("mem_daddress", mem_daddress, e_addr);
    chk("mem_din", mem_din, e_din);
    chk("p0_rdata", rdata[0], e_rdata[0]);
    chk("p1_rdata", rdata[1], e_rdata[1]);
`ifdef DMEM_ARB_RANGE_CHK_EN
    chk("err", 32'(err), 32'(e_err));
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic new_cmd(input int p);
    req[p]   = 1'b1;
    we[p]    = 1'($urandom_range(1, 0));
    wdata[p] = $urandom;
    lock[p]  = ($urandom_range(3, 0) == 0);
    addr[p]  = 32'($urandom_range(c_depth - 1, 0));
    if (c_range && $urandom_range(7, 0) == 0) addr[p] = 32'(c_depth + $urandom_range(63, 0));
  endtask

  int n0, n1, pp;

  initial begin
    for (int i = 0; i < c_depth; i++) begin
      phys_mem[i] = 32'(i);
      ref_mem[i]  = 32'(i);
    end
    mem_dout = '0;
    model_reset();

    // Reset held with both ports requesting reads of 1 and 6.
    reset_n = 1'b0;
    req = 2'b11; we = 2'b00; lock = 2'b00;
    addr[0] = 32'd1; addr[1] = 32'd6; wdata[0] = '0; wdata[1] = '0;
    step();
    step();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    chk("first_gnt_p0", 32'(gnt), 32'b01);
    chk("first_mem_read", 32'(mem_read), 32'd1);
    chk("first_mem_write", 32'(mem_write), 32'd0);
    chk("first_daddress", mem_daddress, 32'd1);

    // Continuous reads from both ports alternate strictly.
    for (int s = 1; s < 8; s++) begin
      step();
      if (s % 2 == 0) begin
        chk("alt_gnt", 32'(gnt), ((s / 2) % 2 == 1) ? 32'b10 : 32'b01);
      end else begin
        pp = ((s - 1) / 2) % 2;
        chk("alt_rvalid", 32'(rvalid), (pp == 1) ? 32'b10 : 32'b01);
        chk("alt_rdata", rdata[pp], (pp == 1) ? 32'd6 : 32'd1);
      end
    end
    req = 2'b00;
    step();

    // Write then read back through port 0.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd6; wdata[0] = 32'hDEADBEEF;
    step();
    chk("wr_mem_write", 32'(mem_write), 32'd1);
    we[0] = 1'b0;
    step();
    chk("gnt_pulse", 32'(gnt[0]), 32'd0);
    chk("wr_no_rvalid", 32'(rvalid[0]), 32'd0);
    step();
    chk("rd_gnt", 32'(gnt[0]), 32'd1);
    req[0] = 1'b0;
    step();
    chk("rd_rvalid", 32'(rvalid[0]), 32'd1);
    chk("rd_rdata", rdata[0], 32'hDEADBEEF);

    // Port 1 locks the arbiter for three grants while port 0 waits.
    req = 2'b11; we = 2'b00; addr[0] = 32'd2; addr[1] = 32'd3; lock[1] = 1'b1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      n0 += int'(gnt[0]);
      n1 += int'(gnt[1]);
      if (gnt[1] && n1 == 3) lock[1] = 1'b0;
    end
    chk("lock_p1_grants", 32'(n1), 32'd3);
    chk("lock_p0_grants", 32'(n0), 32'd0);
    step();
    chk("lock_release_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    step();
    step();

    // Reset pulse in the middle of a port 0 read.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd5;
    step();
    chk("pre_rst_read", 32'(mem_read), 32'd1);
    req[0] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_daddress", mem_daddress, 32'd0);
    chk("rst_p0_rdata", rdata[0], 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    step();
    chk("rst_no_rvalid", 32'(rvalid[0]), 32'd0);

`ifdef DMEM_ARB_RANGE_CHK_EN
    // Out-of-range read: granted, no memory access, error and zero data.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd1024;
    step();
    chk("oor_gnt", 32'(gnt[0]), 32'd1);
    chk("oor_mem_read", 32'(mem_read), 32'd0);
    req[0] = 1'b0;
    step();
    chk("oor_err", 32'(err[0]), 32'd1);
    chk("oor_rvalid", 32'(rvalid[0]), 32'd1);
    chk("oor_rdata", rdata[0], 32'd0);
`endif

    // Random traffic from two independent requesters.
    lock = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || e_gnt[p]) begin
          if ($urandom_range(1, 0) == 1) new_cmd(p);
          else begin
            req[p]  = 1'b0;
            lock[p] = 1'b0;
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
